processor_control_unit: RTL and testbench

- Multi-cycle sequencer for the 8-bit-instruction processor datapath. Fetches each instruction from memory, holds it in an internal IR, and drives the datapath bus-source selects (rout), register load enables (ren), the ALU op select (addxor) and the PC increment.
- Sits between instruction memory and the register/ALU datapath; replaces hand-driven control in the processor top level.

---
 rtl/processor_control_unit.sv | 130 +++++++++++++
 tb/tb_processor_control_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_control_unit.sv
// Multi-cycle fetch/execute sequencer: MV/LDI take 3 cycles, ADD/XOR take 5, plus one per F1 wait cycle.
// Backpressure: the sequencer stalls in F1 while mem_ready is low; halt parks it at the next F0.
module processor_control_unit #(
    parameter int A_IDX    = 8,
    parameter int G_IDX    = 9,
    parameter int PC_IDX   = 11,
    parameter int ADDR_IDX = 13,
    parameter int IMM_IDX  = 14
) (
    input  logic        clock,
    input  logic        resetnot,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    input  logic        halt,
    output logic        mem_read,
    output logic [7:0]  instruction,
    output logic [15:0] rout,
    output logic [15:0] ren,
    output logic        addxor,
    output logic        increment,
    output logic [15:0] imm,
    output logic        done,
    output logic [15:0] retired
);

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_F0   = 3'd1;
    localparam logic [2:0] S_F1   = 3'd2;
    localparam logic [2:0] S_E1   = 3'd3;
    localparam logic [2:0] S_E2   = 3'd4;
    localparam logic [2:0] S_E3   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [7:0]  r_ir;
    logic [15:0] r_retired;
    logic [1:0]  w_op;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic        w_single;

    assign w_op        = r_ir[7:6];
    assign w_rx        = r_ir[5:3];
    assign w_ry        = r_ir[2:0];
    assign w_single    = (w_op == OP_MV) || (w_op == OP_LDI);
    assign instruction = r_ir;
    assign imm         = {13'd0, r_ir[2:0]};
    assign retired     = r_retired;

    always_comb begin
        w_next = S_RST;
        case (r_state)
            S_RST:  w_next = S_F0;
            S_F0:   w_next = halt ? S_HALT : S_F1;
            S_F1:   w_next = mem_ready ? S_E1 : S_F1;
            S_E1:   w_next = w_single ? S_F0 : S_E2;
            S_E2:   w_next = S_E3;
            S_E3:   w_next = S_F0;
            S_HALT: w_next = halt ? S_HALT : S_F0;
            default: w_next = S_RST;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        rout      = 16'd0;
        ren       = 16'd0;
        addxor    = 1'b0;
        increment = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_F0: begin
                // a pending halt suppresses the fetch entirely, including the PC bump
                if (!halt) begin
                    rout      = 16'd1 << PC_IDX;
                    ren       = 16'd1 << ADDR_IDX;
                    increment = 1'b1;
                end
            end
            S_F1: mem_read = 1'b1;
            S_E1: begin
                if (w_op == OP_MV) begin
                    rout = 16'd1 << w_ry;
                    ren  = 16'd1 << w_rx;
                    done = 1'b1;
                end else if (w_op == OP_LDI) begin
                    rout = 16'd1 << IMM_IDX;
                    ren  = 16'd1 << w_rx;
                    done = 1'b1;
                end else begin
                    rout = 16'd1 << w_rx;
                    ren  = 16'd1 << A_IDX;
                end
            end
            S_E2: begin
                rout   = 16'd1 << w_ry;
                ren    = 16'd1 << G_IDX;
                addxor = (w_op == OP_XOR);
            end
            S_E3: begin
                rout = 16'd1 << G_IDX;
                ren  = 16'd1 << w_rx;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            r_state   <= S_RST;
            r_ir      <= 8'h00;
            r_retired <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_F1 && mem_ready) begin
                r_ir <= mem_data;
            end
            if (done) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_processor_control_unit.sv
// Directed bench: per-instruction expected cycle vectors are queued by a model and checked each negedge.
module tb_processor_control_unit;

    localparam int A_IDX    = 8;
    localparam int G_IDX    = 9;
    localparam int PC_IDX   = 11;
    localparam int ADDR_IDX = 13;
    localparam int IMM_IDX  = 14;

    logic        clock = 1'b0;
    logic        resetnot = 1'b1;
    logic [7:0]  mem_data = 8'h00;
    logic        mem_ready = 1'b0;
    logic        halt = 1'b0;
    logic        mem_read;
    logic [7:0]  instruction;
    logic [15:0] rout;
    logic [15:0] ren;
    logic        addxor;
    logic        increment;
    logic [15:0] imm;
    logic        done;
    logic [15:0] retired;

    always #5 clock = ~clock;

    processor_control_unit #(
        .A_IDX(A_IDX), .G_IDX(G_IDX), .PC_IDX(PC_IDX), .ADDR_IDX(ADDR_IDX), .IMM_IDX(IMM_IDX)
    ) dut (
        .clock(clock), .resetnot(resetnot), .mem_data(mem_data), .mem_ready(mem_ready),
        .halt(halt), .mem_read(mem_read), .instruction(instruction), .rout(rout), .ren(ren),
        .addxor(addxor), .increment(increment), .imm(imm), .done(done), .retired(retired)
    );

    typedef struct packed {
        logic        mem_read;
        logic [7:0]  instruction;
        logic [15:0] rout;
        logic [15:0] ren;
        logic        addxor;
        logic        increment;
        logic [15:0] imm;
        logic        done;
        logic [15:0] retired;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  m_ir  = 8'h00;
    logic [15:0] m_ret = 16'd0;

    function automatic logic [15:0] bit16(input int i);
        return 16'd1 << i;
    endfunction

    // Idle vector: only the IR-derived and counter outputs are non-zero.
    function automatic exp_t base();
        exp_t e;
        e = '0;
        e.instruction = m_ir;
        e.imm         = {13'd0, m_ir[2:0]};
        e.retired     = m_ret;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    task automatic step(input exp_t e, input logic [7:0] d, input logic rdy, input logic h);
        @(posedge clock);
        #1;
        q.push_back(e);
        mem_data  = d;
        mem_ready = rdy;
        halt      = h;
    endtask

    task automatic run_instr(input logic [7:0] ir, input int waits, input logic halt_e2);
        exp_t e;
        logic [1:0] op;
        int rx;
        int ry;
        op = ir[7:6];
        rx = int'(ir[5:3]);
        ry = int'(ir[2:0]);
        e = base(); e.rout = bit16(PC_IDX); e.ren = bit16(ADDR_IDX); e.increment = 1'b1;
        step(e, ~ir, 1'b0, 1'b0);
        for (int i = 0; i < waits; i++) begin
            e = base(); e.mem_read = 1'b1;
            step(e, ~ir, 1'b0, 1'b0);
        end
        e = base(); e.mem_read = 1'b1;
        step(e, ir, 1'b1, 1'b0);
        m_ir = ir;
        e = base();
        case (op)
            2'd0: begin e.rout = bit16(ry); e.ren = bit16(rx); e.done = 1'b1; end
            2'd3: begin e.rout = bit16(IMM_IDX); e.ren = bit16(rx); e.done = 1'b1; end
            default: begin e.rout = bit16(rx); e.ren = bit16(A_IDX); end
        endcase
        step(e, 8'h00, 1'b0, 1'b0);
        if (e.done) begin
            m_ret = m_ret + 16'd1;
        end else begin
            e = base(); e.rout = bit16(ry); e.ren = bit16(G_IDX); e.addxor = (op == 2'd2);
            step(e, 8'h00, 1'b0, halt_e2);
            e = base(); e.rout = bit16(G_IDX); e.ren = bit16(rx); e.done = 1'b1;
            step(e, 8'h00, 1'b0, halt_e2);
            m_ret = m_ret + 16'd1;
        end
    endtask

    // n quiet cycles with halt held; halt drops on the last so the next cycle fetches.
    task automatic halt_seq(input int n);
        for (int i = 0; i < n; i++) begin
            step(base(), 8'h00, 1'b0, (i < n - 1));
        end
    endtask

    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clock);
            n_vec++;
            if ($countones(rout) > 1 || $countones(ren) > 1 || (increment && mem_read) ||
                (addxor && (done || mem_read || increment))) begin
                n_bad++;
                $display("FAIL invariant t=%0t rout=%h ren=%h inc=%b rd=%b ax=%b done=%b",
                         $time, rout, ren, increment, mem_read, addxor, done);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                g = '{mem_read, instruction, rout, ren, addxor, increment, imm, done, retired};
                n_vec++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL cycle t=%0t got rd=%b ir=%h rout=%h ren=%h ax=%b inc=%b imm=%h done=%b ret=%h exp rd=%b ir=%h rout=%h ren=%h ax=%b inc=%b imm=%h done=%b ret=%h",
                             $time, g.mem_read, g.instruction, g.rout, g.ren, g.addxor, g.increment,
                             g.imm, g.done, g.retired, e.mem_read, e.instruction, e.rout, e.ren,
                             e.addxor, e.increment, e.imm, e.done, e.retired);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [7:0] ir;
        #1;
        resetnot  = 1'b0;
        mem_data  = 8'b11_010_101;
        mem_ready = 1'b1;
        #2;
        chk("rst_rout", rout, 16'h0000);
        chk("rst_ren", ren, 16'h0000);
        chk("rst_retired", retired, 16'h0000);
        @(posedge clock);
        #1;
        q.push_back(base());
        resetnot = 1'b1;

        // LDI R2,5
        run_instr(8'b11_010_101, 0, 1'b0);
        chk("ldi_rout", rout, 16'h4000);
        chk("ldi_ren", ren, 16'h0004);
        chk("ldi_imm", imm, 16'h0005);
        chk("ldi_done", {15'd0, done}, 16'h0001);

        // ADD R1,R3 then XOR R1,R3
        run_instr(8'b01_001_011, 0, 1'b0);
        chk("add_e3_rout", rout, 16'h0200);
        chk("add_e3_ren", ren, 16'h0002);
        chk("add_e3_retired", retired, 16'h0001);
        run_instr(8'b10_001_011, 0, 1'b0);

        // MV R1,R2 with three not-ready cycles in F1
        run_instr(8'b00_001_010, 3, 1'b0);
        chk("mv_wait_ren", ren, 16'h0002);

        // ADD R3,R3 with halt raised in E2, then parked, then LDI R7,7
        run_instr(8'b01_011_011, 0, 1'b1);
        halt_seq(4);
        run_instr(8'b11_111_111, 0, 1'b0);

        // XOR R4,R5 interrupted by reset during E2
        e = base(); e.rout = bit16(PC_IDX); e.ren = bit16(ADDR_IDX); e.increment = 1'b1;
        step(e, 8'h00, 1'b0, 1'b0);
        e = base(); e.mem_read = 1'b1;
        step(e, 8'b10_100_101, 1'b1, 1'b0);
        m_ir = 8'b10_100_101;
        e = base(); e.rout = bit16(4); e.ren = bit16(A_IDX);
        step(e, 8'h00, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk("e2_addxor", {15'd0, addxor}, 16'h0001);
        chk("e2_rout", rout, 16'h0020);
        #1;
        resetnot = 1'b0;
        #1;
        chk("arst_rout", rout, 16'h0000);
        chk("arst_ren", ren, 16'h0000);
        chk("arst_addxor", {15'd0, addxor}, 16'h0000);
        chk("arst_instr", {8'd0, instruction}, 16'h0000);
        chk("arst_retired", retired, 16'h0000);
        m_ir  = 8'h00;
        m_ret = 16'd0;
        @(posedge clock);
        #1;
        q.push_back(base());
        resetnot = 1'b1;

        // Preload the counter near the top to exercise the wrap
        #6;
        force dut.r_retired = 16'hFFFE;
        #1;
        release dut.r_retired;
        m_ret = 16'hFFFE;
        run_instr(8'b00_000_001, 0, 1'b0);
        run_instr(8'b00_010_011, 1, 1'b0);
        chk("pre_wrap", retired, 16'hFFFF);
        run_instr(8'b00_100_101, 0, 1'b0);
        chk("wrap", retired, 16'h0000);

        // Mixed directed sweep over all ops, operands and occasional F1 stalls
        for (int i = 0; i < 120; i++) begin
            ir = 8'(i * 37 + 11);
            run_instr(ir, (i % 5 == 0) ? 2 : 0, 1'b0);
        end
        chk("sweep_retired", retired, 16'd120);

        @(posedge clock);
        #6;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL queue_drain left=%0d", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
